// File: rtl/serial_sub_ctrl_pkg.sv
// Shared FSM state encoding and default operand width for serial_sub_ctrl.
package serial_sub_ctrl_pkg;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/sub_complete.sv
// One-bit full subtractor: diff = a - b - borrow_in, with borrow out.
module sub_complete (
  input  logic a_i,
  input  logic b_i,
  input  logic borrow_i,
  output logic diff_o,
  output logic borrow_o
);
  assign diff_o   = a_i ^ b_i ^ borrow_i;
  assign borrow_o = (~a_i & b_i) | (~a_i & borrow_i) | (b_i & borrow_i);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor, LSB first, one sub_complete cell per clock.
// Optional Overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
`ifdef SERIAL_SUB_OVF_EN
  output logic             overflow_o,
`endif
  output logic             borrow_out_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, out_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, busy_q, done_q, borrow_out_q;
  logic             cellDiff, cellBorrow;
  logic [WIDTH-1:0] res_d;
  logic             unusedResLsb;

  sub_complete u_cell (
    .a_i      (a_q[0]),
    .b_i      (b_q[0]),
    .borrow_i (borrow_q),
    .diff_o   (cellDiff),
    .borrow_o (cellBorrow)
  );

  // The LSB of the result shifter falls off on every shift and is never consumed.
  assign res_d        = {cellDiff, res_q[WIDTH-1:1]};
  assign unusedResLsb = res_q[0];

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  assign overflow_o = ovf_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      out_q        <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            borrow_q <= borrow_in_i;
            res_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= cellBorrow;
          res_q    <= res_d;
          // Counter holds at its terminal value so it never wraps.
          if (cnt_q == LAST) begin
            out_q        <= res_d;
            borrow_out_q <= cellBorrow;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q        <= borrow_q ^ cellBorrow;
`endif
            done_q       <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign out_o        = out_q;
  assign borrow_out_o = borrow_out_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): vector table plus corner-case sequences.
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;
  import serial_sub_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         borrowIn;
  logic         busy, done, borrowOut;
  logic [W-1:0] diffOut;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  int nApplied = 0;
  int nMiss    = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] expOut;
    logic         expBo;
    logic         expOvf;
  } vec_t;

  vec_t vecs[8];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .a_i          (a),
    .b_i          (b),
    .borrow_in_i  (borrowIn),
    .busy_o       (busy),
    .done_o       (done),
    .out_o        (diffOut),
`ifdef SERIAL_SUB_OVF_EN
    .overflow_o   (overflow),
`endif
    .borrow_out_o (borrowOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Presents operands and holds start across exactly one rising edge (edge 0).
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin);
    @(negedge clk);
    a        = av;
    b        = bv;
    borrowIn = bin;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
  endtask

  int  lat;
  bit  seen;
  int  pulses;
  int  cyc;
  int  prevDone;
  logic [W-1:0] lastOut;

  initial begin
    vecs[0] = '{8'h5A, 8'h1C, 1'b0, 8'h3E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'h33, 8'h44, 1'b0, 8'hEF, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrowIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset out", 32'(diffOut), 32'h0);
    checkOutput("reset borrow_out", 32'(borrowOut), 32'h0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset overflow", 32'(overflow), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin);
      checkOutput($sformatf("v%0d busy after start", i), 32'(busy), 32'h1);
      waitDone(lat, seen);
      checkOutput($sformatf("v%0d done seen", i), 32'(seen), 32'h1);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'd8);
      checkOutput($sformatf("v%0d out", i), 32'(diffOut), 32'(vecs[i].expOut));
      checkOutput($sformatf("v%0d borrow_out", i), 32'(borrowOut), 32'(vecs[i].expBo));
`ifdef SERIAL_SUB_OVF_EN
      checkOutput($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].expOvf));
`endif
      checkOutput($sformatf("v%0d busy in done", i), 32'(busy), 32'h1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d done one cycle", i), 32'(done), 32'h0);
      checkOutput($sformatf("v%0d idle busy", i), 32'(busy), 32'h0);
      checkOutput($sformatf("v%0d out held", i), 32'(diffOut), 32'(vecs[i].expOut));
    end

    // Start with different operands during RUN must be ignored.
    applyStimulus(8'h5A, 8'h1C, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    a = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 8'h00;
    pulses = 0;
    lastOut = '0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        lastOut = diffOut;
      end
    end
    checkOutput("ignored start pulses", 32'(pulses), 32'd1);
    checkOutput("ignored start out", 32'(lastOut), 32'h3E);

    // Reset during RUN aborts the operation and clears outputs.
    applyStimulus(8'h5A, 8'h1C, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort busy", 32'(busy), 32'h0);
    checkOutput("abort done", 32'(done), 32'h0);
    checkOutput("abort out", 32'(diffOut), 32'h0);
    checkOutput("abort borrow_out", 32'(borrowOut), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checkOutput("abort no done", 32'(pulses), 32'd0);
    checkOutput("abort out still 0", 32'(diffOut), 32'h0);
    applyStimulus(8'h10, 8'h01, 1'b0);
    waitDone(lat, seen);
    checkOutput("post-abort done seen", 32'(seen), 32'h1);
    checkOutput("post-abort latency", 32'(lat), 32'd8);
    checkOutput("post-abort out", 32'(diffOut), 32'h0F);
    repeat (2) @(posedge clk);

    // Start held high: back-to-back operations, Done every 10 cycles.
    @(negedge clk);
    a = 8'h5A; b = 8'h1C; borrowIn = 1'b0; start = 1'b1;
    pulses = 0; cyc = 0; prevDone = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        pulses++;
        checkOutput($sformatf("held pulse %0d out", pulses), 32'(diffOut), 32'h3E);
        if (prevDone != 0)
          checkOutput($sformatf("held pulse %0d spacing", pulses), 32'(cyc - prevDone), 32'd10);
        else
          checkOutput("held first latency", 32'(cyc), 32'd9);
        prevDone = cyc;
      end
    end
    start = 1'b0;
    checkOutput("held pulse count", 32'(pulses), 32'd3);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
